// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : Multi-cycle MULT/MULTU/DIV/DIVU unit producing the HI/LO pair,
//               with a pipeline stall request while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             cancel_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int c_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_MUL  = 2'd1;
  localparam logic [1:0] c_DIV  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dsr;
  logic [c_CW-1:0]  r_cnt;

  logic             w_accept;
  logic             w_in_sdiv;
  logic             w_in_dbz;
  logic [WIDTH-1:0] w_in_abs_a;
  logic [WIDTH-1:0] w_in_abs_b;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic             w_sdiv;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;

  assign w_accept   = (r_state == c_IDLE) && start_i && !cancel_i;
  assign w_in_sdiv  = (op_i == 2'b10);
  assign w_in_dbz   = op_i[1] && (opb_i == '0);
  assign w_in_abs_a = (w_in_sdiv && opa_i[WIDTH-1]) ? -opa_i : opa_i;
  assign w_in_abs_b = (w_in_sdiv && opb_i[WIDTH-1]) ? -opb_i : opb_i;

  // Sign- or zero-extend to full product width so one multiplier serves both forms
  assign w_ext_a = {{WIDTH{r_a[WIDTH-1] & ~r_op[0]}}, r_a};
  assign w_ext_b = {{WIDTH{r_b[WIDTH-1] & ~r_op[0]}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // One restoring step: partial remainder never exceeds the divisor, so WIDTH+1 bits suffice
  assign w_trial    = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dsr};
  assign w_fits     = !w_trial[WIDTH];
  assign w_rem_next = w_fits ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};

  assign w_sdiv  = (r_op == 2'b10);
  assign w_q_fin = (w_sdiv && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ? -w_quo_next : w_quo_next;
  assign w_r_fin = (w_sdiv && r_a[WIDTH-1]) ? -w_rem_next : w_rem_next;

  assign stall_o = w_accept || (r_state == c_MUL) || (r_state == c_DIV);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= c_IDLE;
      r_op          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_quo         <= '0;
      r_rem         <= '0;
      r_dsr         <= '0;
      r_cnt         <= '0;
      done_o        <= 1'b0;
      hi_o          <= '0;
      lo_o          <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_op  <= op_i;
            r_a   <= opa_i;
            r_b   <= opb_i;
            r_quo <= w_in_abs_a;
            r_dsr <= w_in_abs_b;
            r_rem <= '0;
            r_cnt <= '0;
            if (w_in_dbz) begin
              r_state       <= c_DONE;
              done_o        <= 1'b1;
              hi_o          <= opa_i;
              lo_o          <= '1;
              div_by_zero_o <= 1'b1;
            end else if (op_i[1]) begin
              r_state <= c_DIV;
            end else begin
              r_state <= c_MUL;
            end
          end
        end
        c_MUL: begin
          if (cancel_i) begin
            r_state <= c_IDLE;
          end else begin
            r_state       <= c_DONE;
            done_o        <= 1'b1;
            hi_o          <= w_prod[2*WIDTH-1:WIDTH];
            lo_o          <= w_prod[WIDTH-1:0];
            div_by_zero_o <= 1'b0;
          end
        end
        c_DIV: begin
          if (cancel_i) begin
            r_state <= c_IDLE;
          end else begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
              r_state       <= c_DONE;
              done_o        <= 1'b1;
              hi_o          <= w_r_fin;
              lo_o          <= w_q_fin;
              div_by_zero_o <= 1'b0;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// Bench for ex_muldiv: directed cases with literal results plus randomized
// traffic checked every cycle against an arithmetic reference model.
module tb_ex_muldiv;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, cancel;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         stall_o, done_o, dbz_o;
  logic [W-1:0] hi_o, lo_o;

  logic         start8, cancel8;
  logic [1:0]   op8;
  logic [7:0]   a8, b8, hi8, lo8;
  logic         stall8, done8, dbz8;

  ex_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .opa_i(a), .opb_i(b),
    .cancel_i(cancel), .stall_o(stall_o), .done_o(done_o), .hi_o(hi_o),
    .lo_o(lo_o), .div_by_zero_o(dbz_o)
  );

  ex_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .op_i(op8), .opa_i(a8), .opb_i(b8),
    .cancel_i(cancel8), .stall_o(stall8), .done_o(done8), .hi_o(hi8),
    .lo_o(lo8), .div_by_zero_o(dbz8)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference arithmetic for one operation
  function automatic void compute(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] h, output logic [W-1:0] l, output bit z);
    longint          sp;
    longint unsigned up;
    int              sx, sy;
    sx = x;
    sy = y;
    z  = 1'b0;
    h  = '0;
    l  = '0;
    case (o)
      2'b00: begin sp = longint'(sx) * longint'(sy); {h, l} = sp; end
      2'b01: begin up = {32'b0, x} * {32'b0, y}; {h, l} = up; end
      default: begin
        if (y == 0) begin
          h = x; l = '1; z = 1'b1;
        end else if (o == 2'b10) begin
          if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            l = 32'h8000_0000; h = '0;
          end else begin
            l = sx / sy; h = sx % sy;
          end
        end else begin
          l = x / y; h = x % y;
        end
      end
    endcase
  endfunction

  // Observable-behaviour model: idle, busy with cycles left, or the done cycle
  bit           m_busy = 0, m_done = 0, m_dbz = 0, p_dbz = 0;
  int           m_left = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_left = 0; m_hi = '0; m_lo = '0; m_dbz = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (cancel) m_busy = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
        end
      end
    end else if (start && !cancel) begin
      compute(op, a, b, p_hi, p_lo, p_dbz);
      if (op[1] && b == 0) begin
        m_done = 1; m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
      end else begin
        m_busy = 1;
        m_left = op[1] ? W : 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("done", done_o, m_done);
      chk("stall", stall_o, m_busy || (!m_done && start && !cancel));
      chk("hi", hi_o, m_hi);
      chk("lo", lo_o, m_lo);
      chk("dbz", dbz_o, m_dbz);
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int exp_lat, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input bit ez, input string nm);
    int cyc;
    bit found;
    start = 1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 0; a = $urandom; b = $urandom;
    cyc = 1; found = 0;
    while (!found && cyc < 200) begin
      @(negedge clk);
      if (done_o === 1'b1) found = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    chk({nm, "_latency"}, cyc, exp_lat);
    chk({nm, "_hi"}, hi_o, eh);
    chk({nm, "_lo"}, lo_o, el);
    chk({nm, "_dbz"}, dbz_o, ez);
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return W'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc, dcount;
    bit found;
    rst = 1; start = 0; cancel = 0; op = 0; a = 0; b = 0;
    start8 = 0; cancel8 = 0; op8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done", done_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_dbz", dbz_o, 0);
    chk("rst8_hilo", {hi8, lo8, done8, dbz8}, 0);
    @(posedge clk); #1;
    rst = 0;
    chk_en = 1;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 2, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, "mult");
    run_op(2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14, 0, "divu");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, "div_neg");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 0, "div_ovf");
    run_op(2'b11, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1, "divu_zero");
    run_op(2'b01, 32'd2, 32'h8000_0001, 2, 32'd1, 32'd2, 0, "multu");

    // DIVU with start held through busy, flushed in cycle 10
    start = 1; op = 2'b11; a = 32'd1000; b = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      a = $urandom; b = $urandom;
      if (c == 10) cancel = 1;
    end
    @(posedge clk); #1;
    cancel = 0; start = 0;
    @(negedge clk);
    chk("cancel_stall", stall_o, 0);
    chk("cancel_hi", hi_o, 32'd1);
    chk("cancel_lo", lo_o, 32'd2);
    dcount = 0;
    repeat (40) begin @(posedge clk); #1; @(negedge clk); if (done_o) dcount++; end
    chk("cancel_no_done", dcount, 0);

    // Reset in cycle 5 of a DIV
    @(posedge clk); #1;
    start = 1; op = 2'b10; a = 32'hFFFF_FF9C; b = 32'd7;
    @(posedge clk); #1;
    start = 0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rstmid_outputs", {done_o, stall_o, dbz_o, hi_o, lo_o}, 0);
    dcount = 0;
    repeat (40) begin @(posedge clk); #1; @(negedge clk); if (done_o) dcount++; end
    chk("rstmid_no_done", dcount, 0);

    // WIDTH=8 build: DIVU 200/3
    @(posedge clk); #1;
    start8 = 1; op8 = 2'b11; a8 = 8'd200; b8 = 8'd3;
    @(posedge clk); #1;
    start8 = 0; a8 = 0; b8 = 0;
    cyc = 1; found = 0;
    while (!found && cyc < 50) begin
      @(negedge clk);
      if (done8 === 1'b1) found = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    chk("w8_latency", cyc, 9);
    chk("w8_lo", lo8, 8'd66);
    chk("w8_hi", hi8, 8'd2);
    @(posedge clk); #1;

    // Randomized traffic, including flushes and occasional reset
    repeat (3000) begin
      start  = ($urandom % 4 == 0);
      cancel = ($urandom % 30 == 0);
      rst    = ($urandom % 700 == 0);
      op     = 2'($urandom);
      a      = pick();
      b      = pick();
      @(posedge clk); #1;
    end
    start = 0; cancel = 0; rst = 0;
    repeat (40) begin @(posedge clk); #1; end
    @(negedge clk);
    chk_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
# ex_muldiv

Multi-cycle multiply/divide unit that sits beside the single-cycle execute stage ALU and produces the HI/LO result pair for MULT, MULTU, DIV and DIVU. The operand width is parametrised. Multiplies complete in a fixed 2 cycles; divides use a WIDTH-iteration restoring divider. While an operation is in flight the block raises a stall request to the pipeline. Results are held on hi_o/lo_o until the next operation completes, so the HI/LO writeback path can sample them on done_o.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  request a new operation; sampled only in IDLE.
- op_i  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- opa_i  in  WIDTH  multiplicand / dividend; captured on accepted start.
- opb_i  in  WIDTH  multiplier / divisor; captured on accepted start.
- cancel_i  in  1  pipeline flush (branch/exception); aborts an in-flight operation.
- stall_o  out  1  stall request to the pipeline front-end.
- done_o  out  1  one-cycle pulse; hi_o/lo_o hold a new result.
- hi_o  out  WIDTH  multiply: upper product half. Divide: remainder.
- lo_o  out  WIDTH  multiply: lower product half. Divide: quotient.
- div_by_zero_o  out  1  valid with done_o; set when a DIV/DIVU had opb = 0.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - start_i=1 with cancel_i=0 captures op/opa/opb.
  - Next state is MUL for op 00/01 and DIV for op 10/11.
  - For a divide with opb = 0, the next state is DONE directly.
- MUL:
  - Registers the full 2*WIDTH product. Signed for op 00, unsigned for op 01.
  - Next state: DONE.
- DIV:
  - Operates on magnitudes: |a| and |b| for DIV, raw values for DIVU.
  - Each cycle performs one restoring step: shift in the next dividend bit, trial-subtract the divisor, set the quotient bit.
  - An iteration counter runs 0..WIDTH-1; the state moves to DONE after the iteration with counter = WIDTH-1.
- DONE:
  - done_o=1; hi_o/lo_o are updated on the edge that enters DONE.
  - Next state: IDLE unconditionally.
- Sign correction (DIV only), applied on entry to DONE:
  - Quotient is negated if sign(a)^sign(b).
  - Remainder takes the sign of a.
  - Most-negative / -1 gives quotient = most-negative (wraps) and remainder 0. No trap.
- Divide by zero:
  - lo_o = all ones, hi_o = opa.
  - div_by_zero_o=1 for the DONE cycle.
- stall_o = (state==IDLE && start_i && !cancel_i) || state==MUL || state==DIV. It is low in DONE, so the stalled instruction retires in the DONE cycle.
- start_i outside IDLE is ignored; there is no queuing.
- cancel_i:
  - In MUL or DIV: next state IDLE, no done_o, hi_o/lo_o/div_by_zero_o unchanged.
  - In DONE: no effect, since the result has already committed.
  - In IDLE: any start_i in the same cycle is suppressed.
- hi_o/lo_o change only on entry to DONE.

## Timing
- Reset values: state IDLE, done_o 0, stall_o 0, hi_o 0, lo_o 0, div_by_zero_o 0, counter 0.
- Reset has priority over every other input and aborts any operation immediately; no done_o follows.
- Cycle numbering: start accepted on the edge ending cycle 0.
  - MUL: done_o in cycle 2.
  - DIV/DIVU: done_o in cycle WIDTH+1 (33 for WIDTH=32).
  - Divide by zero: done_o in cycle 1.
- stall_o is high for cycles 0..1 (MUL) or 0..WIDTH (DIV), and low in the done_o cycle.
- A new start_i may be accepted in the cycle after DONE (back-to-back throughput: MUL 3 cycles, DIV WIDTH+2 cycles).
- All outputs are registered except stall_o, which is combinational from state, start_i and cancel_i.

## Test plan
- MULT, opa=0xFFFFFFFD (-3), opb=5 -> done_o in cycle 2, hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall_o high cycles 0-1 only.
- DIVU, 100 / 7 -> done_o in cycle 33, lo=14, hi=2, div_by_zero_o=0; DIV, -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV, 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU, 5 / 0 -> done_o in cycle 1, lo=0xFFFFFFFF, hi=5, div_by_zero_o=1.
- DIVU started after a completed MULTU (hi=1, lo=2), cancel_i in cycle 10 -> IDLE in cycle 11, no done_o, hi=1, lo=2 retained; start_i held high during busy is ignored.
- rst asserted in cycle 5 of a DIV -> all outputs 0 the next cycle, no done_o; WIDTH=8 build, DIVU 200/3 -> done_o in cycle 9, lo=66, hi=2.
